sram_sprite_reader: RTL and testbench

- Read-side SRAM client for sprite images stored by the frame encoder. One image per object ID, row-major, IMAGE_SIZE x IMAGE_SIZE.
- Accepts pixel read requests (object ID, h, v) over a valid/ready handshake and drives the SRAM read address.
- Samples SRAM data after a fixed latency and expands RGB565 to RGB888 with a transparency flag.
- Returns results in request order through a response FIFO with valid/ready handshake.
- Yields the SRAM bus whenever the encoder is writing.

---
 rtl/sram_sprite_reader.sv | 131 +++++++++++++
 tb/tb_sram_sprite_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sprite_reader.sv
// Sprite pixel reader: turns (obj, h, v) requests into SRAM reads, expands RGB565 to RGB888
// and returns in-order responses through a credit-protected FIFO.
module sram_sprite_reader #(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_SIZE   = 64,
  parameter int COOR_WIDTH   = 7,
  parameter int OBJ_WIDTH    = 3,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT_KEY = 16'hF81F
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [OBJ_WIDTH-1:0]  i_req_obj,
  input  logic [COOR_WIDTH-1:0] i_req_h,
  input  logic [COOR_WIDTH-1:0] i_req_v,
  input  logic                  i_sram_writing,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [23:0]           o_rsp_color,
  output logic                  o_rsp_opaque,
  output logic                  o_rsp_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic vld;
    logic oob;
    logic err;
  } stage_t;

  typedef struct packed {
    logic [23:0] color;
    logic        opaque;
    logic        err;
  } rsp_t;

  stage_t                pipe [READ_LATENCY];
  stage_t                tail;
  rsp_t                  mem  [FIFO_DEPTH];
  rsp_t                  rsp_new, head;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count, in_flight;
  logic [CW:0]           credit_used;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_oob, accept, push, pop;
  logic [7:0]            r8, g8, b8;

  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(in_flight);
  assign o_req_ready = !i_rst && !i_sram_writing && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign accept      = i_req_valid && o_req_ready;

  assign req_oob  = (32'(i_req_h) >= IMAGE_SIZE) || (32'(i_req_v) >= IMAGE_SIZE);
  assign req_addr = ADDR_WIDTH'(i_req_obj) * ADDR_WIDTH'(IMAGE_SIZE * IMAGE_SIZE)
                  + ADDR_WIDTH'(i_req_v) * ADDR_WIDTH'(IMAGE_SIZE)
                  + ADDR_WIDTH'(i_req_h);

  always_ff @(posedge i_clk) begin
    if (i_rst)                    o_sram_addr <= '0;
    else if (accept && !req_oob)  o_sram_addr <= req_addr;
  end

  // Each stage accumulates any write seen while the read is outstanding.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{vld: accept, oob: req_oob, err: 1'b0};
      for (int i = 1; i < READ_LATENCY; i++)
        pipe[i] <= '{vld: pipe[i-1].vld, oob: pipe[i-1].oob, err: pipe[i-1].err | i_sram_writing};
    end
  end

  assign tail = pipe[READ_LATENCY-1];
  assign push = tail.vld;
  assign r8   = {i_sram_data[15:11], i_sram_data[15:13]};
  assign g8   = {i_sram_data[10:5],  i_sram_data[10:9]};
  assign b8   = {i_sram_data[4:0],   i_sram_data[4:2]};

  always_comb begin
    rsp_new = '0;
    if (!tail.oob) begin
      if (tail.err || i_sram_writing) begin
        rsp_new.err = 1'b1;
      end else if (i_sram_data != TRANSPARENT_KEY) begin
        rsp_new.color  = {r8, g8, b8};
        rsp_new.opaque = 1'b1;
      end
    end
  end

  assign head         = mem[rd_ptr];
  assign o_rsp_valid  = (fifo_count != '0);
  assign o_rsp_color  = head.color;
  assign o_rsp_opaque = head.opaque;
  assign o_rsp_err    = head.err;
  assign pop          = o_rsp_valid && i_rsp_ready;

  // Storage is cleared on reset so the head fields read as zero afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_flight  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rsp_new;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
      case ({accept, push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_sprite_reader.sv
// Bench for sram_sprite_reader: transaction-level reference model with per-cycle compare,
// plus directed scenarios pinned with literal expectations.
module tb_sram_sprite_reader;
  localparam int AW = 20, DW = 16, IS = 64, CWD = 7, OW = 3, RL = 2, FD = 4;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_req_valid = 1'b0;
  logic            o_req_ready;
  logic [OW-1:0]   i_req_obj = '0;
  logic [CWD-1:0]  i_req_h = '0, i_req_v = '0;
  logic            i_sram_writing = 1'b0;
  logic [AW-1:0]   o_sram_addr;
  logic [DW-1:0]   i_sram_data = '0;
  logic            o_rsp_valid;
  logic            i_rsp_ready = 1'b1;
  logic [23:0]     o_rsp_color;
  logic            o_rsp_opaque, o_rsp_err;

  always #5 clk = ~clk;

  sram_sprite_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMAGE_SIZE(IS), .COOR_WIDTH(CWD), .OBJ_WIDTH(OW),
    .READ_LATENCY(RL), .FIFO_DEPTH(FD), .TRANSPARENT_KEY(16'hF81F)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_obj(i_req_obj), .i_req_h(i_req_h), .i_req_v(i_req_v),
    .i_sram_writing(i_sram_writing), .o_sram_addr(o_sram_addr), .i_sram_data(i_sram_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_color(o_rsp_color),
    .o_rsp_opaque(o_rsp_opaque), .o_rsp_err(o_rsp_err)
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // SRAM image: sparse overrides on top of an address-derived pattern.
  logic [15:0] smem [int];
  function automatic logic [15:0] sram_word(input int a);
    if (smem.exists(a)) return smem[a];
    return 16'(a) ^ 16'hA5C3;
  endfunction

  // Data appears RL edges after the address is registered.
  logic [AW-1:0] addr_q = '0;
  always @(negedge clk) begin
    i_sram_data = sram_word(int'(addr_q));
    addr_q      = o_sram_addr;
  end

  typedef struct packed {
    logic [23:0] color;
    logic        opaque;
    logic        err;
  } exp_t;

  typedef struct {
    int          rem;
    logic        oob;
    logic        err;
    logic [15:0] word;
  } pend_t;

  function automatic exp_t expand(input logic [15:0] d);
    exp_t e;
    int r, g, b;
    e = '0;
    if (d == 16'hF81F) return e;
    r = int'(d) / 2048;
    g = (int'(d) / 32) % 64;
    b = int'(d) % 32;
    e.color  = 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
    e.opaque = 1'b1;
    return e;
  endfunction

  pend_t         pend [$];
  exp_t          expq [$];
  exp_t          rsp_log [$];
  logic [AW-1:0] m_addr = '0;

  function automatic logic m_ready();
    return !i_rst && !i_sram_writing && ((expq.size() + pend.size()) < FD);
  endfunction

  always @(posedge clk) begin
    logic  rdy;
    pend_t p;
    exp_t  e;
    int    a;
    rdy = m_ready();
    if (i_rst) begin
      pend.delete();
      expq.delete();
      m_addr = '0;
    end else begin
      if (expq.size() != 0 && i_rsp_ready) void'(expq.pop_front());
      for (int i = 0; i < pend.size(); i++) begin
        if (i_sram_writing) pend[i].err = 1'b1;
        pend[i].rem--;
      end
      while (pend.size() != 0 && pend[0].rem == 0) begin
        p = pend.pop_front();
        e = '0;
        if (!p.oob) begin
          if (p.err) e.err = 1'b1;
          else       e = expand(p.word);
        end
        expq.push_back(e);
      end
      if (i_req_valid && rdy) begin
        a      = (int'(i_req_obj) * IS * IS + int'(i_req_v) * IS + int'(i_req_h)) % (1 << AW);
        p.rem  = RL;
        p.oob  = (int'(i_req_h) >= IS) || (int'(i_req_v) >= IS);
        p.err  = 1'b0;
        p.word = sram_word(a);
        pend.push_back(p);
        if (!p.oob) m_addr = AW'(a);
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("req_ready", 32'(o_req_ready), 32'(m_ready()));
    chk("sram_addr", 32'(o_sram_addr), 32'(m_addr));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(expq.size() != 0));
    if (o_rsp_valid && expq.size() != 0) begin
      chk("rsp_color",  32'(o_rsp_color),  32'(expq[0].color));
      chk("rsp_opaque", 32'(o_rsp_opaque), 32'(expq[0].opaque));
      chk("rsp_err",    32'(o_rsp_err),    32'(expq[0].err));
      if (i_rsp_ready) rsp_log.push_back('{o_rsp_color, o_rsp_opaque, o_rsp_err});
    end
  end

  task automatic send(input int obj, input int h, input int v);
    int t = 0;
    i_req_valid = 1'b1;
    i_req_obj   = OW'(obj);
    i_req_h     = CWD'(h);
    i_req_v     = CWD'(v);
    #1;
    while (!o_req_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'(0));
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output exp_t r, output int cyc);
    cyc = 0;
    #1;
    while (!o_rsp_valid && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    if (cyc >= 20) chk("rsp_timeout", 32'(cyc), 32'(0));
    r = '{o_rsp_color, o_rsp_opaque, o_rsp_err};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t r;
    int   cyc, acc, t, base;
    logic [15:0] kw [3];
    logic [23:0] kc [3];
    logic        ko [3];
    kw[0] = 16'h07E0; kc[0] = 24'h00FF00; ko[0] = 1'b1;
    kw[1] = 16'hF81F; kc[1] = 24'h000000; ko[1] = 1'b0;
    kw[2] = 16'h0000; kc[2] = 24'h000000; ko[2] = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 32'(o_req_ready), 32'(0));
    chk("reset_valid", 32'(o_rsp_valid), 32'(0));
    chk("reset_addr",  32'(o_sram_addr), 32'(0));
    chk("reset_color", 32'(o_rsp_color), 32'(0));
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);

    // basic read with fixed latency
    smem[32'h01083] = 16'hF800;
    send(1, 3, 2);
    #1 chk("basic_addr", 32'(o_sram_addr), 32'h01083);
    wait_rsp(r, cyc);
    chk("basic_latency", 32'(cyc), 32'(RL));
    chk("basic_color", 32'(r.color), 32'hFF0000);
    chk("basic_opaque", 32'(r.opaque), 32'(1));
    chk("basic_err", 32'(r.err), 32'(0));
    @(negedge clk);

    // expansion and transparency key
    for (int k = 0; k < 3; k++) begin
      smem[32'h2000 + k] = kw[k];
      send(2, k, 0);
      wait_rsp(r, cyc);
      chk("expand_color", 32'(r.color), 32'(kc[k]));
      chk("expand_opaque", 32'(r.opaque), 32'(ko[k]));
      @(negedge clk);
    end

    // backpressure: credits stop acceptance at FIFO_DEPTH
    i_rsp_ready = 1'b0;
    base = rsp_log.size();
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      i_req_valid = 1'b1; i_req_obj = 3'd3; i_req_v = 7'd1; i_req_h = CWD'(acc);
      #1 if (o_req_ready) acc++;
      @(negedge clk);
    end
    chk("bp_accepted", 32'(acc), 32'(4));
    #1 chk("bp_ready_low", 32'(o_req_ready), 32'(0));
    @(negedge clk);
    i_rsp_ready = 1'b1;
    t = 0;
    while (acc < 8 && t < 100) begin
      i_req_h = CWD'(acc);
      #1 if (o_req_ready) acc++;
      @(negedge clk);
      t++;
    end
    i_req_valid = 1'b0;
    chk("bp_all_accepted", 32'(acc), 32'(8));
    repeat (8) @(negedge clk);
    chk("bp_rsp_count", 32'(rsp_log.size() - base), 32'(8));
    for (int k = 0; k < 8; k++)
      if (base + k < rsp_log.size())
        chk("bp_order", 32'(rsp_log[base + k].color), 32'(expand(sram_word(3 * 4096 + 64 + k)).color));

    // out-of-range request keeps its slot and leaves the address alone
    base = rsp_log.size();
    send(0, 5, 5);
    #1 chk("oob_addr_first", 32'(o_sram_addr), 32'h145);
    @(negedge clk);
    send(0, 64, 0);
    #1 chk("oob_addr_held", 32'(o_sram_addr), 32'h145);
    @(negedge clk);
    send(0, 6, 5);
    repeat (6) @(negedge clk);
    chk("oob_rsp_count", 32'(rsp_log.size() - base), 32'(3));
    if (rsp_log.size() - base == 3) begin
      chk("oob_mid_color",  32'(rsp_log[base + 1].color),  32'(0));
      chk("oob_mid_opaque", 32'(rsp_log[base + 1].opaque), 32'(0));
      chk("oob_mid_err",    32'(rsp_log[base + 1].err),    32'(0));
      chk("oob_last_color", 32'(rsp_log[base + 2].color),  32'(expand(sram_word(32'h146)).color));
    end

    // write collision while a read is outstanding
    send(4, 1, 1);
    i_sram_writing = 1'b1;
    #1 chk("coll_ready", 32'(o_req_ready), 32'(0));
    @(negedge clk);
    i_sram_writing = 1'b0;
    wait_rsp(r, cyc);
    chk("coll_err", 32'(r.err), 32'(1));
    chk("coll_opaque", 32'(r.opaque), 32'(0));
    chk("coll_color", 32'(r.color), 32'(0));
    @(negedge clk);

    // reset with responses queued and reads in flight
    i_rsp_ready = 1'b0;
    send(5, 0, 0);
    send(5, 1, 0);
    repeat (4) @(negedge clk);
    send(5, 2, 0);
    send(5, 3, 0);
    base = rsp_log.size();
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("mid_rst_valid",  32'(o_rsp_valid),  32'(0));
    chk("mid_rst_color",  32'(o_rsp_color),  32'(0));
    chk("mid_rst_opaque", 32'(o_rsp_opaque), 32'(0));
    chk("mid_rst_err",    32'(o_rsp_err),    32'(0));
    chk("mid_rst_addr",   32'(o_sram_addr),  32'(0));
    i_rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_stale", 32'(rsp_log.size() - base), 32'(0));
    smem[32'h061C7] = 16'h001F;
    send(6, 7, 7);
    wait_rsp(r, cyc);
    chk("post_rst_color", 32'(r.color), 32'h0000FF);
    chk("post_rst_opaque", 32'(r.opaque), 32'(1));
    chk("post_rst_err", 32'(r.err), 32'(0));
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
